aes_decrypt_iter: RTL

Iterative AES-128 decryptor. It is the receive-side counterpart of AES_Encrypt: it takes a 128-bit ciphertext and 128-bit cipher key and returns the plaintext.
- One inverse round per clock, with the inverse key schedule computed on the fly.
- A one-entry cache of the last-round key lets back-to-back blocks under the same key skip forward key expansion.
- Sits between the link/storage interface and the consumer of plaintext, fed with blocks produced by AES_Encrypt.

---
 rtl/aes_pkg.sv | 108 ++++++++++
 rtl/aes_inv_round.sv | 41 ++++
 rtl/aes_decrypt_iter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions: S-boxes, Rcon, GF(2^8) helpers and key-schedule steps.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_ROUND
    } aes_state_e;

    // One accepted job: ciphertext plus the key it was encrypted under.
    typedef struct packed {
        logic [127:0] din;
        logic [127:0] key;
    } aes_job_t;

    // Entry 0 sits in the top byte so a table row reads left to right.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TAB[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TAB[{~x, 3'b000} +: 8];
    endfunction

    // Round constant for round i (1..10); other indices never occur.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (9, 11, 13, 14 are the ones used here).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
               (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // rk_(i-1) -> rk_i
    function automatic logic [127:0] key_fwd_step(input logic [127:0] rk, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon(i), 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rk_i -> rk_(i-1); the old w3 must be recovered before the old w0.
    function automatic logic [127:0] key_inv_step(input logic [127:0] rk, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rcon(i), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] sub_q;
    logic [127:0] ark;
    logic [127:0] mix;

    assign ark    = sub_q ^ rk;
    assign result = last ? ark : mix;

    for (genvar c = 0; c < 4; c++) begin : g_col
        // Row r of column c comes from column (c - r) mod 4 of the input.
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign sub_q[127 - 8 * DST -: 8] = inv_sbox(state[127 - 8 * SRC -: 8]);
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127 - 32 * c -: 8];
        assign a1 = ark[119 - 32 * c -: 8];
        assign a2 = ark[111 - 32 * c -: 8];
        assign a3 = ark[103 - 32 * c -: 8];

        assign mix[127 - 32 * c -: 32] = {
            gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)
        };
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10 (skipped on a
// cache hit), then ten inverse rounds walking the key schedule backwards.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter bit CACHE_KEY = 1'b1,
    parameter int NR        = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] din,
    input  logic [127:0] k,
    output logic         ready,
    output logic [127:0] dout,
    output logic         dout_valid,
    output logic         key_hit
);

    if (NR != AES_NR) begin : g_bad_nr
        $error("aes_decrypt_iter: only NR=10 (AES-128) is supported");
    end

    aes_state_e   st, st_nxt;
    logic [3:0]   rnd;
    aes_job_t     job;
    logic [127:0] rk;
    logic [127:0] state_q;
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic         cache_vld;

    logic         hit;
    logic         last;
    logic [127:0] rk_fwd;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    assign ready   = (st == ST_IDLE);
    assign hit     = CACHE_KEY && cache_vld && (k == cache_key);
    assign last    = (rnd == 4'd0);
    assign rk_fwd  = key_fwd_step(rk, rnd);
    // rk holds rk_(rnd+1) during ROUND; step back to the key this round uses.
    assign rk_prev = key_inv_step(rk, rnd + 4'd1);

    aes_inv_round u_round (
        .state  (state_q),
        .rk     (rk_prev),
        .last   (last),
        .result (round_out)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) st <= ST_IDLE;
        else          st <= st_nxt;
    end

    // Next-state: expansion ends after rk10, rounds end after round 0.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:   if (start) st_nxt = hit ? ST_ROUND : ST_EXPAND;
            ST_EXPAND: if (rnd == 4'd10) st_nxt = ST_ROUND;
            ST_ROUND:  if (rnd == 4'd0) st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    // Datapath, round counter, key cache and outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rnd        <= 4'd0;
            job        <= '0;
            rk         <= '0;
            state_q    <= '0;
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            key_hit    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        job.din <= din;
                        job.key <= k;
                        key_hit <= hit;
                        if (hit) begin
                            state_q <= din ^ cache_rk10;
                            rk      <= cache_rk10;
                            rnd     <= 4'd9;
                        end else begin
                            rk      <= k;
                            rnd     <= 4'd1;
                        end
                    end
                end
                ST_EXPAND: begin
                    rk <= rk_fwd;
                    if (rnd == 4'd10) begin
                        state_q <= job.din ^ rk_fwd;
                        rnd     <= 4'd9;
                        if (CACHE_KEY) begin
                            cache_key  <= job.key;
                            cache_rk10 <= rk_fwd;
                            cache_vld  <= 1'b1;
                        end
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_ROUND: begin
                    rk      <= rk_prev;
                    state_q <= round_out;
                    if (last) begin
                        dout       <= round_out;
                        dout_valid <= 1'b1;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
